sbm_result_serializer: RTL and testbench

//  Downstream stage of the sbm_digitized multiplier. Captures the full-width product c once
//  the controller flags it final. Streams it out LS word first as WORD-bit words over a

---
 rtl/sbm_result_serializer.sv | 114 +++++++++++
 tb/tb_sbm_result_serializer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbm_result_serializer.sv
// Result serializer: captures the wide product and streams it LS word first over valid/ready.
// Optional build macro SBM_SER_CHECKSUM_EN appends an XOR checksum word to every frame.
module sbm_result_serializer #(
  parameter int SIZEC = 2048,
  parameter int WORD  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZEC-1:0] c_in,
  input  logic             c_valid,
  output logic             c_ready,
  output logic [WORD-1:0]  dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy
);

  localparam int NWORDS = (SIZEC + WORD - 1) / WORD;
  localparam int CNTW   = $clog2(NWORDS + 1);
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NWORDS - 1);

`ifdef SBM_SER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_t;
`endif

  state_t                       state, state_next;
  logic [CNTW-1:0]              cnt;
  logic [IDXW-1:0]              idx;
  // Zero-padded to whole words so bits above SIZEC read back as 0 in the last word
  logic [NWORDS-1:0][WORD-1:0]  shadow;
  logic                         capture;
  logic                         xfer;
`ifdef SBM_SER_CHECKSUM_EN
  logic [WORD-1:0]              csum;
`endif

  assign idx = cnt[IDXW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    c_ready    = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    dout       = '0;
    capture    = 1'b0;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        c_ready = 1'b1;
        if (c_valid) begin
          capture    = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        dout_valid = 1'b1;
        dout       = shadow[idx];
`ifndef SBM_SER_CHECKSUM_EN
        dout_last  = (cnt == LAST_CNT);
`endif
        if (dout_ready) begin
          xfer = 1'b1;
          if (cnt == LAST_CNT) begin
`ifdef SBM_SER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_IDLE;
`endif
          end
        end
      end
`ifdef SBM_SER_CHECKSUM_EN
      ST_CSUM: begin
        dout_valid = 1'b1;
        dout       = csum;
        dout_last  = 1'b1;
        if (dout_ready) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
    busy = ~c_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (capture) begin
      shadow <= (NWORDS * WORD)'(c_in);
      cnt    <= '0;
    end else if (xfer) begin
      cnt    <= cnt + 1'b1;
    end
  end

`ifdef SBM_SER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          csum <= '0;
    else if (capture) csum <= '0;
    else if (xfer)    csum <= csum ^ dout;
  end
`endif

endmodule

// File: tb/tb_sbm_result_serializer.sv
// Self-checking bench for sbm_result_serializer: queue-based frame model plus directed literal checks.
// Follows SBM_SER_CHECKSUM_EN so expectations match whichever build is compiled.
module tb_sbm_result_serializer;

  localparam int SIZEC = 2048;
  localparam int WORD  = 64;
  localparam int NW    = SIZEC / WORD;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SIZEC-1:0] c_in = '0;
  logic             c_valid = 1'b0;
  logic             c_ready;
  logic [WORD-1:0]  dout;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic             dout_last;
  logic             busy;

  logic [99:0]      c_in_s = '1;
  logic             c_valid_s = 1'b0;
  logic             c_ready_s;
  logic [63:0]      dout_s;
  logic             dout_valid_s;
  logic             dout_ready_s = 1'b1;
  logic             dout_last_s;
  logic             busy_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbm_result_serializer #(.SIZEC(SIZEC), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .c_in(c_in), .c_valid(c_valid), .c_ready(c_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy));

  sbm_result_serializer #(.SIZEC(100), .WORD(64)) dut_s (
    .clk(clk), .rst(rst), .c_in(c_in_s), .c_valid(c_valid_s), .c_ready(c_ready_s),
    .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready_s),
    .dout_last(dout_last_s), .busy(busy_s));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of (word, last) entries; idle exactly when the list is empty
  typedef struct { logic [63:0] w; logic l; } ent_t;
  ent_t q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (c_valid) begin
        logic [63:0] x;
        x = '0;
        for (int i = 0; i < NW; i++) begin
          ent_t e;
          e.w = c_in[i*WORD +: WORD];
          x   = x ^ e.w;
`ifdef SBM_SER_CHECKSUM_EN
          e.l = 1'b0;
`else
          e.l = (i == NW - 1);
`endif
          q.push_back(e);
        end
`ifdef SBM_SER_CHECKSUM_EN
        begin
          ent_t c;
          c.w = x;
          c.l = 1'b1;
          q.push_back(c);
        end
`endif
      end
    end else if (dout_ready) begin
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      chk("m_valid", dout_valid, 1);
      chk("m_dout", dout, q[0].w);
      chk("m_last", dout_last, q[0].l);
      chk("m_c_ready", c_ready, 0);
      chk("m_busy", busy, 1);
    end else begin
      chk("m_valid_idle", dout_valid, 0);
      chk("m_dout_idle", dout, 0);
      chk("m_last_idle", dout_last, 0);
      chk("m_c_ready_idle", c_ready, 1);
      chk("m_busy_idle", busy, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_idx();
    for (int i = 0; i < NW; i++) c_in[i*WORD +: WORD] = 64'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < SIZEC / 32; i++) c_in[i*32 +: 32] = $urandom;
  endtask

  task automatic start_frame();
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (c_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("drain_c_ready", c_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("reset_c_ready", c_ready, 1);
    chk("reset_valid", dout_valid, 0);
    chk("reset_dout", dout, 0);
    rst = 1'b0;
    tick();

    // 1: index pattern, full-rate drain
    fill_idx();
    dout_ready = 1'b1;
    start_frame();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("t1_dout", dout, 64'(i));
`ifdef SBM_SER_CHECKSUM_EN
      chk("t1_last", dout_last, 0);
`else
      chk("t1_last", dout_last, (i == NW - 1) ? 1 : 0);
`endif
    end
`ifdef SBM_SER_CHECKSUM_EN
    @(negedge clk);
    chk("t1_csum", dout, 0);
    chk("t1_csum_last", dout_last, 1);
`endif
    @(negedge clk);
    chk("t1_c_ready_back", c_ready, 1);
    tick();

    // 2: stall on word 7
    start_frame();
    repeat (7) tick();
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_dout", dout, 7);
      chk("t2_hold_valid", dout_valid, 1);
      tick();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("t2_still7", dout, 7);
    tick();
    @(negedge clk);
    chk("t2_word8", dout, 8);
    tick();
    drain();

    // 3: c_valid while busy is ignored
    start_frame();
    repeat (12) tick();
    fill_rand();
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    @(negedge clk);
    chk("t3_word13", dout, 13);
    tick();
    drain();
    repeat (3) tick();
    chk("t3_no_new_frame", c_ready, 1);

    // 4: asynchronous reset during word 10
    fill_idx();
    start_frame();
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t4_valid", dout_valid, 0);
    chk("t4_last", dout_last, 0);
    chk("t4_dout", dout, 0);
    chk("t4_busy", busy, 0);
    chk("t4_c_ready", c_ready, 1);
    tick();
    #3;
    rst = 1'b0;
    tick();
    start_frame();
    @(negedge clk);
    chk("t4_restart_w0", dout, 0);
    tick();
    @(negedge clk);
    chk("t4_restart_w1", dout, 1);
    tick();
    drain();

    // 5: single nonzero word
    c_in = '0;
    c_in[3*WORD +: WORD] = 64'hDEAD_BEEF_0000_0001;
    start_frame();
    c_in = '1;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("t5_dout", dout, (i == 3) ? 64'hDEAD_BEEF_0000_0001 : 64'h0);
    end
`ifdef SBM_SER_CHECKSUM_EN
    @(negedge clk);
    chk("t5_csum", dout, 64'hDEAD_BEEF_0000_0001);
    chk("t5_csum_last", dout_last, 1);
`endif
    tick();
    drain();

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fill_rand();
      c_valid    = ($urandom_range(0, 3) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    c_valid    = 1'b0;
    dout_ready = 1'b1;
    drain();

    // 6: SIZEC=100 partial last word
    c_valid_s = 1'b1;
    tick();
    c_valid_s = 1'b0;
    @(negedge clk);
    chk("t6_w0", dout_s, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_w0_last", dout_last_s, 0);
    @(negedge clk);
    chk("t6_w1", dout_s, 64'h0000_000F_FFFF_FFFF);
`ifdef SBM_SER_CHECKSUM_EN
    chk("t6_w1_last", dout_last_s, 0);
    @(negedge clk);
    chk("t6_csum", dout_s, 64'hFFFF_FFF0_0000_0000);
    chk("t6_csum_last", dout_last_s, 1);
`else
    chk("t6_w1_last", dout_last_s, 1);
`endif
    @(negedge clk);
    chk("t6_c_ready", c_ready_s, 1);
    chk("t6_valid_off", dout_valid_s, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
